// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with burst line refill, single-cycle
// fence.i invalidation and hit/access counters.
module icache #(
  parameter int unsigned SETS_LOG2       = 8,
  parameter int unsigned LINE_WORDS_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic        imem_oe,
  output logic [31:0] imem_rdata,
  output logic        imem_valid,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] cnt_hit,
  output logic [31:0] cnt_access
);
  localparam int unsigned Sets   = 1 << SETS_LOG2;
  localparam int unsigned Words  = 1 << LINE_WORDS_LOG2;
  localparam int unsigned IdxLsb = 2 + LINE_WORDS_LOG2;
  localparam int unsigned TagLsb = IdxLsb + SETS_LOG2;
  localparam int unsigned TagW   = 32 - TagLsb;

  typedef enum logic [2:0] {StIdle, StLookup, StReq, StFill, StResp} state_e;

  state_e                     state_q, state_d;
  logic [31:0]                addr_q;
  logic [31:0]                rd_word_q;
  logic [TagW-1:0]            rd_tag_q;
  logic [31:0]                resp_q;
  logic [LINE_WORDS_LOG2-1:0] beat_q;
  logic                       fill_flushed_q;
  logic                       hold_valid_q;
  logic [31:0]                hold_rdata_q;
  logic [31:0]                cnt_hit_q, cnt_access_q;
  logic [Sets-1:0]            valid_q;
  logic [TagW-1:0]            tag_q  [Sets];
  logic [31:0]                data_q [Sets*Words];

  logic [SETS_LOG2-1:0]       req_idx;
  logic [LINE_WORDS_LOG2-1:0] req_off;
  logic [TagW-1:0]            req_tag;
  logic                       hit, accept, beat_fire, last_beat, set_valid;
  logic                       unused_addr;

  assign unused_addr = ^imem_addr[1:0];

  assign req_idx   = addr_q[IdxLsb +: SETS_LOG2];
  assign req_off   = addr_q[2 +: LINE_WORDS_LOG2];
  assign req_tag   = addr_q[TagLsb +: TagW];
  assign hit       = (state_q == StLookup) && valid_q[req_idx] && (rd_tag_q == req_tag);
  assign accept    = imem_oe && ((state_q == StIdle) || (state_q == StResp) || hit);
  assign beat_fire = (state_q == StFill) && mem_rvalid;
  assign last_beat = beat_fire && (beat_q == LINE_WORDS_LOG2'(Words - 1));
  // A flush seen anywhere during the refill keeps the refilled line invalid.
  assign set_valid = last_beat && !fill_flushed_q && !flush;

  assign mem_addr   = {addr_q[31:IdxLsb], {IdxLsb{1'b0}}};
  assign cnt_hit    = cnt_hit_q;
  assign cnt_access = cnt_access_q;

  always_comb begin
    state_d    = state_q;
    imem_valid = hold_valid_q;
    imem_rdata = hold_rdata_q;
    mem_req    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StLookup;
      end
      StLookup: begin
        if (hit) begin
          imem_valid = 1'b1;
          imem_rdata = rd_word_q;
          state_d    = accept ? StLookup : StIdle;
        end else begin
          imem_valid = 1'b0;
          state_d    = StReq;
        end
      end
      StReq: begin
        imem_valid = 1'b0;
        mem_req    = 1'b1;
        if (mem_gnt) state_d = StFill;
      end
      StFill: begin
        imem_valid = 1'b0;
        if (last_beat) state_d = StResp;
      end
      StResp: begin
        imem_valid = 1'b1;
        imem_rdata = resp_q;
        state_d    = accept ? StLookup : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      resp_q         <= '0;
      beat_q         <= '0;
      fill_flushed_q <= 1'b0;
      hold_valid_q   <= 1'b0;
      hold_rdata_q   <= '0;
      cnt_hit_q      <= '0;
      cnt_access_q   <= '0;
      valid_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= imem_valid;
      hold_rdata_q <= imem_rdata;
      if (accept) begin
        addr_q       <= imem_addr;
        cnt_access_q <= cnt_access_q + 32'd1;
      end
      if (hit) cnt_hit_q <= cnt_hit_q + 32'd1;
      if (state_q == StReq) beat_q <= '0;
      if (beat_fire) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == req_off) resp_q <= mem_rdata;
      end
      if (state_q == StLookup) fill_flushed_q <= 1'b0;
      else if (flush && ((state_q == StReq) || (state_q == StFill))) fill_flushed_q <= 1'b1;
      if (flush) valid_q <= '0;
      if (set_valid) valid_q[req_idx] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_q <= data_q[imem_addr[2 +: SETS_LOG2 + LINE_WORDS_LOG2]];
      rd_tag_q  <= tag_q[imem_addr[IdxLsb +: SETS_LOG2]];
    end
    if (beat_fire) data_q[{req_idx, beat_q}] <= mem_rdata;
    if (last_beat) tag_q[req_idx] <= req_tag;
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold/conflict misses, back-to-back hits,
// stall hold, flush interactions and reset in the middle of a refill.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr = '0;
  logic        imem_oe = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] cnt_hit, cnt_access;

  int checks = 0;
  int failures = 0;
  int exp_acc = 0;
  int exp_hit = 0;

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_oe    (imem_oe),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .cnt_hit    (cnt_hit),
    .cnt_access (cnt_access)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one fetch; returns in the cycle after acceptance (LOOKUP).
  task automatic fetch_start(input logic [31:0] a);
    imem_addr = a;
    imem_oe   = 1'b1;
    exp_acc++;
    tick();
    imem_oe   = 1'b0;
  endtask

  // Backing-memory driver, entered in a REQ cycle; returns in the RESP cycle.
  // bad counts cycles where the stall outputs were not as a miss requires.
  task automatic serve(input int gnt_delay, input logic [31:0] w0, input bit gaps,
                       input int flush_beat, output logic [31:0] got_addr, output int bad);
    bad = 0;
    for (int i = 0; i < gnt_delay; i++) begin
      if (imem_valid !== 1'b0 || mem_req !== 1'b1) bad++;
      tick();
    end
    if (imem_valid !== 1'b0 || mem_req !== 1'b1) bad++;
    got_addr = mem_addr;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (imem_valid !== 1'b0 || mem_req !== 1'b0) bad++;
      mem_rvalid = 1'b1;
      mem_rdata  = w0 + 32'(b);
      flush      = (b == flush_beat);
      tick();
      mem_rvalid = 1'b0;
      flush      = 1'b0;
      if (gaps && b < 3) begin
        if (imem_valid !== 1'b0) bad++;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_valid !== 1'b0 || imem_rdata !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0
        || cnt_hit !== 32'h0 || cnt_access !== 32'h0) begin
      failures++;
      $display("FAIL reset_values got valid=%b rdata=%h req=%b addr=%h hit=%0d acc=%0d exp all 0",
               imem_valid, imem_rdata, mem_req, mem_addr, cnt_hit, cnt_access);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    logic [31:0] a;
    int bad;
    fetch_start(32'h100);
    checks++;
    if (imem_valid !== 1'b0) begin
      failures++;
      $display("FAIL cold_lookup_valid got=%b exp=0", imem_valid);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL cold_req_n2 got=%b exp=1", mem_req);
    end
    serve(2, 32'hA0, 1'b0, -1, a, bad);
    checks++;
    if (a !== 32'h100) begin
      failures++;
      $display("FAIL cold_mem_addr got=%h exp=%h", a, 32'h100);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL cold_stall got=%0d bad cycles exp=0", bad);
    end
    checks++;
    if (imem_valid !== 1'b1 || imem_rdata !== 32'hA0) begin
      failures++;
      $display("FAIL cold_resp got valid=%b rdata=%h exp valid=1 rdata=000000a0",
               imem_valid, imem_rdata);
    end
    checks++;
    if (cnt_access !== 32'(exp_acc) || cnt_hit !== 32'(exp_hit)) begin
      failures++;
      $display("FAIL cold_counters got acc=%0d hit=%0d exp acc=%0d hit=%0d",
               cnt_access, cnt_hit, exp_acc, exp_hit);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    addrs = '{32'h104, 32'h108, 32'h10C};
    words = '{32'hA1, 32'hA2, 32'hA3};
    imem_oe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_addr = addrs[i];
      exp_acc++;
      exp_hit++;
      tick();
      checks++;
      if (imem_valid !== 1'b1 || imem_rdata !== words[i] || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL b2b_hit%0d got valid=%b rdata=%h req=%b exp valid=1 rdata=%h req=0",
                 i, imem_valid, imem_rdata, mem_req, words[i]);
      end
    end
    imem_oe = 1'b0;
    tick();
    checks++;
    if (cnt_hit !== 32'(exp_hit) || cnt_access !== 32'(exp_acc)) begin
      failures++;
      $display("FAIL b2b_counters got hit=%0d acc=%0d exp hit=%0d acc=%0d",
               cnt_hit, cnt_access, exp_hit, exp_acc);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] a;
    int bad;
    fetch_start(32'h110C);
    checks++;
    if (imem_valid !== 1'b0) begin
      failures++;
      $display("FAIL conflict_miss1 got valid=%b exp=0", imem_valid);
    end
    tick();
    serve(0, 32'hB0, 1'b1, -1, a, bad);
    checks++;
    if (a !== 32'h1100 || bad !== 0) begin
      failures++;
      $display("FAIL conflict_refill1 got addr=%h bad=%0d exp addr=00001100 bad=0", a, bad);
    end
    checks++;
    if (imem_valid !== 1'b1 || imem_rdata !== 32'hB3) begin
      failures++;
      $display("FAIL conflict_critical_word got valid=%b rdata=%h exp valid=1 rdata=000000b3",
               imem_valid, imem_rdata);
    end
    // Issued during RESP: must be accepted like an IDLE request.
    fetch_start(32'h100);
    checks++;
    if (imem_valid !== 1'b0) begin
      failures++;
      $display("FAIL conflict_miss2 got valid=%b exp=0", imem_valid);
    end
    tick();
    serve(0, 32'hA0, 1'b0, -1, a, bad);
    checks++;
    if (a !== 32'h100 || imem_valid !== 1'b1 || imem_rdata !== 32'hA0) begin
      failures++;
      $display("FAIL conflict_refill2 got addr=%h valid=%b rdata=%h exp addr=00000100 valid=1 rdata=000000a0",
               a, imem_valid, imem_rdata);
    end
    tick();
  endtask

  task automatic test_stall_hold();
    fetch_start(32'h104);
    exp_hit++;
    checks++;
    if (imem_valid !== 1'b1 || imem_rdata !== 32'hA1) begin
      failures++;
      $display("FAIL stall_hit got valid=%b rdata=%h exp valid=1 rdata=000000a1",
               imem_valid, imem_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (imem_valid !== 1'b1 || imem_rdata !== 32'hA1) begin
        failures++;
        $display("FAIL stall_hold%0d got valid=%b rdata=%h exp valid=1 rdata=000000a1",
                 i, imem_valid, imem_rdata);
      end
    end
    checks++;
    if (cnt_hit !== 32'(exp_hit) || cnt_access !== 32'(exp_acc)) begin
      failures++;
      $display("FAIL stall_counters got hit=%0d acc=%0d exp hit=%0d acc=%0d",
               cnt_hit, cnt_access, exp_hit, exp_acc);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a;
    int bad;
    fetch_start(32'h208);
    tick();
    serve(0, 32'hC0, 1'b0, 1, a, bad);
    checks++;
    if (imem_valid !== 1'b1 || imem_rdata !== 32'hC2 || bad !== 0) begin
      failures++;
      $display("FAIL flush_fill_resp got valid=%b rdata=%h bad=%0d exp valid=1 rdata=000000c2 bad=0",
               imem_valid, imem_rdata, bad);
    end
    tick();
    fetch_start(32'h208);
    checks++;
    if (imem_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_refetch_miss got valid=%b exp=0", imem_valid);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL flush_refetch_req got=%b exp=1", mem_req);
    end
    serve(0, 32'hC0, 1'b0, -1, a, bad);
    tick();
    fetch_start(32'h104);
    checks++;
    if (imem_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_other_line_miss got valid=%b exp=0", imem_valid);
    end
    tick();
    serve(0, 32'hA0, 1'b0, -1, a, bad);
    tick();
    fetch_start(32'h208);
    flush = 1'b1;
    exp_hit++;
    checks++;
    if (imem_valid !== 1'b1 || imem_rdata !== 32'hC2) begin
      failures++;
      $display("FAIL flush_with_hit got valid=%b rdata=%h exp valid=1 rdata=000000c2",
               imem_valid, imem_rdata);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (cnt_hit !== 32'(exp_hit) || cnt_access !== 32'(exp_acc)) begin
      failures++;
      $display("FAIL flush_counters got hit=%0d acc=%0d exp hit=%0d acc=%0d",
               cnt_hit, cnt_access, exp_hit, exp_acc);
    end
    fetch_start(32'h208);
    checks++;
    if (imem_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_after_hit_miss got valid=%b exp=0", imem_valid);
    end
    tick();
    serve(0, 32'hC0, 1'b0, -1, a, bad);
    tick();
  endtask

  task automatic test_reset_mid_fill();
    fetch_start(32'h300);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hD0 + 32'(b);
      tick();
    end
    mem_rvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_acc = 0;
    exp_hit = 0;
    checks++;
    if (imem_valid !== 1'b0 || imem_rdata !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0
        || cnt_hit !== 32'h0 || cnt_access !== 32'h0) begin
      failures++;
      $display("FAIL midfill_reset got valid=%b rdata=%h req=%b addr=%h hit=%0d acc=%0d exp all 0",
               imem_valid, imem_rdata, mem_req, mem_addr, cnt_hit, cnt_access);
    end
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hEE;
      tick();
    end
    mem_rvalid = 1'b0;
    checks++;
    if (imem_valid !== 1'b0 || imem_rdata !== 32'h0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL midfill_stray got valid=%b rdata=%h req=%b exp valid=0 rdata=0 req=0",
               imem_valid, imem_rdata, mem_req);
    end
    fetch_start(32'h300);
    checks++;
    if (imem_valid !== 1'b0) begin
      failures++;
      $display("FAIL midfill_refetch_miss got valid=%b exp=0", imem_valid);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h300 || cnt_access !== 32'(exp_acc)) begin
      failures++;
      $display("FAIL midfill_refetch_req got req=%b addr=%h acc=%0d exp req=1 addr=00000300 acc=%0d",
               mem_req, mem_addr, cnt_access, exp_acc);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_stall_hold();
    test_flush();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
